// File: rtl/rotary_bank_pkg.sv
// Shared opcodes, instruction field helpers and the quadrature step decoder
// used by the rotary_bank peripheral and its channels.
package rotary_bank_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SEL  = 4'h1;
  localparam logic [3:0] OP_CLRL = 4'h2;
  localparam logic [3:0] OP_CLRR = 4'h3;
  localparam logic [3:0] OP_CLRC = 4'h4;
  localparam logic [3:0] OP_MODE = 4'h5;
  localparam logic [3:0] OP_CLRE = 4'h6;

  // Mode bits: bit0 saturate(1)/wrap(0), bit1 1x(1)/4x(0)
  localparam int MODE_SAT_BIT = 0;
  localparam int MODE_1X_BIT  = 1;

  typedef struct packed {
    logic valid;
    logic dir;      // 1 = right (+1), 0 = left (-1)
    logic illegal;
  } step_t;

  function automatic logic [3:0] inst_opcode(input logic [11:0] inst);
    return inst[11:8];
  endfunction

  function automatic logic [7:0] inst_imm(input logic [11:0] inst);
    return inst[7:0];
  endfunction

  // Position of an AB pair along the right-turn sequence 00->01->11->10
  function automatic logic [1:0] ab_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t      s;
    logic [1:0] diff;
    s    = '0;
    diff = ab_pos(cur) - ab_pos(prev);
    if ((prev ^ cur) == 2'b11) begin
      s.illegal = 1'b1;
    end else if (diff == 2'd1) begin
      s.valid = 1'b1;
      s.dir   = 1'b1;
    end else if (diff == 2'd3) begin
      s.valid = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/rotary_bank_channel.sv
// One encoder channel: 2-FF sync, stability filter, registered step decoder,
// signed step counter and sticky left/right flags.
module rotary_channel
  import rotary_bank_pkg::*;
#(
  parameter int         COUNT_WIDTH = 8,
  parameter int         DEBOUNCE    = 4,
  parameter logic [1:0] RESET_MODE  = 2'b00
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             rotary,
  input  logic                   clr_l,
  input  logic                   clr_r,
  input  logic                   clr_c,
  input  logic                   mode_we,
  input  logic [1:0]             mode_in,
  output logic                   left_status,
  output logic                   right_status,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   illegal
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic [COUNT_WIDTH-1:0] CNT_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

  logic [1:0] sync1_reg, sync2_reg;
  logic [1:0] sync_vld_reg;
  logic [1:0] filt;
  logic       filt_vld;

  // sync_vld keeps reset-state synchroniser contents out of the filter
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      sync_vld_reg <= '0;
    end else begin
      sync1_reg    <= rotary;
      sync2_reg    <= sync1_reg;
      sync_vld_reg <= {sync_vld_reg[0], 1'b1};
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign filt     = sync2_reg;
      assign filt_vld = sync_vld_reg[1];
    end else begin : g_debounce
      localparam int             DB_W   = $clog2(DEBOUNCE + 1);
      localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);

      logic [1:0]      last_reg, filt_reg;
      logic [DB_W-1:0] cnt_reg, cnt_next;
      logic            filt_vld_reg;

      // cnt counts cycles the synchronised value has been seen unchanged
      always_comb begin
        cnt_next = cnt_reg;
        if (!sync_vld_reg[1]) begin
          cnt_next = '0;
        end else if (sync2_reg != last_reg) begin
          cnt_next = DB_W'(1);
        end else if (cnt_reg != DB_MAX) begin
          cnt_next = cnt_reg + DB_W'(1);
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          last_reg     <= '0;
          filt_reg     <= '0;
          cnt_reg      <= '0;
          filt_vld_reg <= 1'b0;
        end else begin
          last_reg <= sync2_reg;
          cnt_reg  <= cnt_next;
          if (cnt_next == DB_MAX) begin
            filt_reg     <= sync2_reg;
            filt_vld_reg <= 1'b1;
          end
        end
      end

      assign filt     = filt_reg;
      assign filt_vld = filt_vld_reg;
    end
  endgenerate

  logic                   armed_reg;
  logic [1:0]             prev_reg;
  logic [1:0]             mode_reg;
  logic [COUNT_WIDTH-1:0] count_reg, count_next, count_base;
  logic                   left_reg, left_next, right_reg, right_next;
  logic                   decode_en, take;
  step_t                  step;

  always_comb begin
    step       = decode_step(prev_reg, filt);
    decode_en  = armed_reg && filt_vld && (filt != prev_reg);
    take       = decode_en && step.valid && (!mode_reg[MODE_1X_BIT] || filt == 2'b00);
    illegal    = decode_en && step.illegal;
    count_base = clr_c ? '0 : count_reg;
    count_next = count_base;
    if (take) begin
      if (step.dir) begin
        if (!(mode_reg[MODE_SAT_BIT] && count_base == CNT_MAX)) begin
          count_next = count_base + COUNT_WIDTH'(1);
        end
      end else begin
        if (!(mode_reg[MODE_SAT_BIT] && count_base == CNT_MIN)) begin
          count_next = count_base - COUNT_WIDTH'(1);
        end
      end
    end
    // A step in the same cycle as a clear leaves the flag set
    left_next  = (take && !step.dir) || (left_reg && !clr_l);
    right_next = (take && step.dir) || (right_reg && !clr_r);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      armed_reg <= 1'b0;
      prev_reg  <= '0;
      mode_reg  <= RESET_MODE;
      count_reg <= '0;
      left_reg  <= 1'b0;
      right_reg <= 1'b0;
    end else begin
      if (filt_vld) begin
        prev_reg  <= filt;
        armed_reg <= 1'b1;
      end
      if (mode_we) begin
        mode_reg <= mode_in;
      end
      count_reg <= count_next;
      left_reg  <= left_next;
      right_reg <= right_next;
    end
  end

  assign left_status  = left_reg;
  assign right_status = right_reg;
  assign count        = count_reg;

endmodule

// File: rtl/rotary_bank.sv
// Multi-channel quadrature encoder bank on the sequencer inst bus: instruction
// decode, channel select, sticky error and the registered selected-count output.
module rotary_bank
  import rotary_bank_pkg::*;
#(
  parameter int         CHANNELS    = 2,
  parameter int         COUNT_WIDTH = 8,
  parameter int         DEBOUNCE    = 4,
  parameter logic [1:0] RESET_MODE  = 2'b00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [11:0]             inst,
  input  logic                    inst_en,
  input  logic [2*CHANNELS-1:0]   rotary,
  output logic [CHANNELS-1:0]     rotary_left_status,
  output logic [CHANNELS-1:0]     rotary_right_status,
  output logic [COUNT_WIDTH-1:0]  rotary_count,
  output logic                    rotary_error
);

  localparam int         SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int         NSLOT  = 2 ** SEL_W;
  localparam logic [8:0] CH_LIM = 9'(CHANNELS);

  logic [3:0]             opcode;
  logic [7:0]             imm;
  logic                   do_sel, sel_ok, do_clrl, do_clrr, do_clrc, do_mode, do_clre;
  logic [SEL_W-1:0]       sel_reg;
  logic                   error_reg, error_next;
  logic [CHANNELS-1:0]    ch_illegal;
  logic [COUNT_WIDTH-1:0] ch_count [NSLOT];

  always_comb begin
    opcode  = inst_opcode(inst);
    imm     = inst_imm(inst);
    do_sel  = inst_en && (opcode == OP_SEL);
    do_clrl = inst_en && (opcode == OP_CLRL);
    do_clrr = inst_en && (opcode == OP_CLRR);
    do_clrc = inst_en && (opcode == OP_CLRC);
    do_mode = inst_en && (opcode == OP_MODE);
    do_clre = inst_en && (opcode == OP_CLRE);
    sel_ok  = {1'b0, imm} < CH_LIM;
    // Any new error outranks a same-cycle CLRE
    if ((do_sel && !sel_ok) || (|ch_illegal)) begin
      error_next = 1'b1;
    end else if (do_clre) begin
      error_next = 1'b0;
    end else begin
      error_next = error_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_reg      <= '0;
      error_reg    <= 1'b0;
      rotary_count <= '0;
    end else begin
      if (do_sel && sel_ok) begin
        sel_reg <= imm[SEL_W-1:0];
      end
      error_reg    <= error_next;
      rotary_count <= ch_count[sel_reg];
    end
  end

  assign rotary_error = error_reg;

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_ch
      if (gi < CHANNELS) begin : g_live
        logic hit;
        assign hit = (sel_reg == SEL_W'(gi));

        rotary_channel #(
          .COUNT_WIDTH (COUNT_WIDTH),
          .DEBOUNCE    (DEBOUNCE),
          .RESET_MODE  (RESET_MODE)
        ) u_channel (
          .clock        (clock),
          .reset        (reset),
          .rotary       (rotary[2*gi +: 2]),
          .clr_l        (do_clrl && hit),
          .clr_r        (do_clrr && hit),
          .clr_c        (do_clrc && hit),
          .mode_we      (do_mode && hit),
          .mode_in      (imm[1:0]),
          .left_status  (rotary_left_status[gi]),
          .right_status (rotary_right_status[gi]),
          .count        (ch_count[gi]),
          .illegal      (ch_illegal[gi])
        );
      end else begin : g_pad
        assign ch_count[gi] = '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_rotary_bank.sv
// Scoreboard bench for rotary_bank: stimulus updates a spec-level model and
// queues timed expectations; a negedge monitor pops and compares them.
module tb_rotary_bank;

  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int DB   = 4;
  localparam int VW   = 2*CH + W + 1;
  localparam int CMAX = 2**(W-1) - 1;
  localparam int CMIN = -(2**(W-1));

  logic            clock = 1'b0;
  logic            reset;
  logic [11:0]     inst;
  logic            inst_en;
  logic [2*CH-1:0] rotary;
  logic [CH-1:0]   rotary_left_status, rotary_right_status;
  logic [W-1:0]    rotary_count;
  logic            rotary_error;

  rotary_bank #(.CHANNELS(CH), .COUNT_WIDTH(W), .DEBOUNCE(DB), .RESET_MODE(2'b00)) dut (
    .clock               (clock),
    .reset               (reset),
    .inst                (inst),
    .inst_en             (inst_en),
    .rotary              (rotary),
    .rotary_left_status  (rotary_left_status),
    .rotary_right_status (rotary_right_status),
    .rotary_count        (rotary_count),
    .rotary_error        (rotary_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [VW-1:0] outvec;
  assign outvec = {rotary_left_status, rotary_right_status, rotary_count, rotary_error};

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            cyc;
    string         name;
    logic [VW-1:0] exp;
  } rec_t;
  rec_t sb[$];

  // ---------------- reference model ----------------
  int         cnt_m   [CH];
  bit         left_m  [CH];
  bit         right_m [CH];
  bit [1:0]   mode_m  [CH];
  logic [1:0] prev_m  [CH];
  int         sel_m;
  bit         err_m;
  logic [1:0] seq_ab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int pos_of(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (seq_ab[i] == ab) return i;
    return 0;
  endfunction

  function void model_reset();
    for (int i = 0; i < CH; i++) begin
      cnt_m[i] = 0; left_m[i] = 0; right_m[i] = 0; mode_m[i] = 2'b00;
    end
    sel_m = 0;
    err_m = 0;
  endfunction

  function void model_arm();
    for (int i = 0; i < CH; i++) prev_m[i] = rotary[2*i +: 2];
  endfunction

  function void model_ab(input int ch, input logic [1:0] ab);
    int d, n;
    if (ab == prev_m[ch]) return;
    d = (pos_of(ab) - pos_of(prev_m[ch]) + 4) % 4;
    prev_m[ch] = ab;
    if (d == 2) begin
      err_m = 1;
      return;
    end
    if (mode_m[ch][1] && ab != 2'b00) return;
    n = cnt_m[ch] + ((d == 1) ? 1 : -1);
    if (n > CMAX) n = mode_m[ch][0] ? CMAX : CMIN;
    if (n < CMIN) n = mode_m[ch][0] ? CMIN : CMAX;
    cnt_m[ch] = n;
    if (d == 1) right_m[ch] = 1; else left_m[ch] = 1;
  endfunction

  // Clears act before a same-cycle step so that the step wins
  function void model_inst_pre(input logic [11:0] ins);
    logic [3:0] op;
    op = ins[11:8];
    case (op)
      4'h2: left_m[sel_m]  = 0;
      4'h3: right_m[sel_m] = 0;
      4'h4: cnt_m[sel_m]   = 0;
      4'h6: err_m          = 0;
      default: ;
    endcase
  endfunction

  // SEL and MODE take effect after any same-cycle step
  function void model_inst_post(input logic [11:0] ins);
    logic [3:0] op;
    logic [7:0] imm;
    op  = ins[11:8];
    imm = ins[7:0];
    if (op == 4'h1) begin
      if (int'(imm) < CH) sel_m = int'(imm); else err_m = 1;
    end else if (op == 4'h5) begin
      mode_m[sel_m] = imm[1:0];
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [CH-1:0] l, r;
    logic [W-1:0]  cv;
    for (int i = 0; i < CH; i++) begin
      l[i] = left_m[i];
      r[i] = right_m[i];
    end
    cv = W'(cnt_m[sel_m]);
    return {l, r, cv, err_m};
  endfunction

  // ---------------- monitor ----------------
  rec_t mon_rec;
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_rec = sb.pop_front();
      vectors++;
      if (mon_rec.cyc != cyc || outvec !== mon_rec.exp) begin
        miscompares++;
        $display("FAIL %s @cyc %0d (due %0d): got %h want %h",
                 mon_rec.name, cyc, mon_rec.cyc, outvec, mon_rec.exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input int c, input string name, input logic [VW-1:0] e);
    rec_t r;
    r.cyc = c; r.name = name; r.exp = e;
    sb.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  // Pin change at cycle c: old outputs at c+DB+2, flags at c+DB+3, count out at c+DB+4.
  // An optional instruction lands on the decode edge.
  task automatic do_pin(input int ch, input logic [1:0] ab, input bit with_inst,
                        input logic [11:0] ins, input string name);
    logic [VW-1:0] old_v, mid_v, new_v;
    int c;
    @(negedge clock);
    c = cyc;
    old_v = exp_vec();
    rotary[2*ch +: 2] = ab;
    if (with_inst) model_inst_pre(ins);
    model_ab(ch, ab);
    if (with_inst) model_inst_post(ins);
    new_v = exp_vec();
    mid_v = new_v;
    mid_v[W:1] = old_v[W:1];
    push(c + DB + 2, {name, "_pre"}, old_v);
    push(c + DB + 3, {name, "_flags"}, mid_v);
    push(c + DB + 4, {name, "_count"}, new_v);
    repeat (DB + 2) @(negedge clock);
    if (with_inst) begin
      inst = ins; inst_en = 1'b1;
    end
    @(negedge clock);
    inst = '0; inst_en = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic step_ch(input int ch, input bit right, input bit with_inst,
                         input logic [11:0] ins, input string name);
    logic [1:0] ab;
    ab = seq_ab[(pos_of(rotary[2*ch +: 2]) + (right ? 1 : 3)) % 4];
    do_pin(ch, ab, with_inst, ins, name);
  endtask

  task automatic do_inst(input logic [11:0] ins, input bit en, input string name);
    int c;
    @(negedge clock);
    c = cyc;
    inst = ins; inst_en = en;
    if (en) begin
      model_inst_pre(ins);
      model_inst_post(ins);
    end
    push(c + 2, name, exp_vec());
    @(negedge clock);
    inst = '0; inst_en = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic glitch_a0(input string name);
    int c;
    @(negedge clock);
    c = cyc;
    rotary[1] = ~rotary[1];
    push(c + DB + 6, name, exp_vec());
    repeat (DB - 1) @(negedge clock);
    rotary[1] = ~rotary[1];
    repeat (DB + 5) @(negedge clock);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; inst = '0; inst_en = 1'b0; rotary = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_state", 32'(outvec), 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    model_arm();

    // 4x right steps on ch0
    for (int i = 0; i < 4; i++) step_ch(0, 1'b1, 1'b0, 12'h000, "t1_right");
    drain();
    check("t1_count", 32'(rotary_count), 32'd4);
    check("t1_right", 32'(rotary_right_status), 32'h1);
    check("t1_left", 32'(rotary_left_status), 32'h0);

    // 1x mode, three full left cycles on ch1
    do_inst(12'h101, 1'b1, "t2_sel1");
    do_inst(12'h502, 1'b1, "t2_mode1x");
    for (int i = 0; i < 12; i++) step_ch(1, 1'b0, 1'b0, 12'h000, "t2_left");
    drain();
    check("t2_count", 32'(rotary_count), 32'h0000_00FD);
    check("t2_left1", 32'(rotary_left_status[1]), 32'h1);

    // saturate then wrap on ch1
    do_inst(12'h501, 1'b1, "t3_mode_sat");
    do_inst(12'h400, 1'b1, "t3_clrc");
    for (int i = 0; i < 130; i++) step_ch(1, 1'b1, 1'b0, 12'h000, "t3_sat");
    drain();
    check("t3_sat_count", 32'(rotary_count), 32'h7F);
    do_inst(12'h500, 1'b1, "t3_mode_wrap");
    do_inst(12'h400, 1'b1, "t3_clrc2");
    for (int i = 0; i < 130; i++) step_ch(1, 1'b1, 1'b0, 12'h000, "t3_wrap");
    drain();
    check("t3_wrap_count", 32'(rotary_count), 32'h82);

    // glitch, illegal jump, CLRE on ch0
    do_inst(12'h100, 1'b1, "t4_sel0");
    glitch_a0("t4_glitch");
    do_pin(0, rotary[1:0] ^ 2'b11, 1'b0, 12'h000, "t4_illegal");
    drain();
    check("t4_error", 32'(rotary_error), 32'h1);
    check("t4_count_held", 32'(rotary_count), 32'd4);
    do_inst(12'h600, 1'b1, "t4_clre");
    drain();
    check("t4_error_clr", 32'(rotary_error), 32'h0);

    // clears racing a step
    do_inst(12'h300, 1'b1, "t5_clrr");
    step_ch(0, 1'b1, 1'b1, 12'h300, "t5_step_clrr");
    drain();
    check("t5_right_kept", 32'(rotary_right_status[0]), 32'h1);
    step_ch(0, 1'b1, 1'b1, 12'h400, "t5_step_clrc");
    drain();
    check("t5_count_one", 32'(rotary_count), 32'd1);

    // bad SEL, then reset during a step
    do_inst(12'h109, 1'b1, "t6_sel9");
    drain();
    check("t6_sel_error", 32'(rotary_error), 32'h1);
    check("t6_sel_kept", 32'(rotary_count), 32'd1);
    rotary[1:0] = seq_ab[(pos_of(rotary[1:0]) + 1) % 4];
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_reset_mid_step", 32'(outvec), 32'd0);
    rotary[1:0] = 2'b10;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (12) @(negedge clock);
    model_arm();
    check("t6_post_reset", 32'(outvec), 32'd0);

    // randomized mix
    for (int t = 0; t < 80; t++) begin
      int         kind, ch;
      logic [3:0] op;
      logic [7:0] imm;
      kind = $urandom_range(0, 9);
      ch   = $urandom_range(0, CH - 1);
      op   = 4'($urandom_range(0, 9));
      imm  = (op == 4'h1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if (kind < 5) begin
        step_ch(ch, 1'($urandom_range(0, 1)), 1'b0, 12'h000, "rnd_step");
      end else if (kind == 5) begin
        do_pin(ch, rotary[2*ch +: 2] ^ 2'b11, 1'b0, 12'h000, "rnd_illegal");
      end else if (kind == 6) begin
        step_ch(ch, 1'($urandom_range(0, 1)), 1'b1, {op, imm}, "rnd_step_inst");
      end else begin
        do_inst({op, imm}, (kind != 9), "rnd_inst");
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (40000) @(posedge clock);
    $display("FAIL watchdog: bench did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
